// File: rtl/uart_cmd_bridge_if.sv
// Command, read-port, error and serial signals of uart_cmd_bridge.
// slave is the bridge side; master is the user logic that issues commands and feeds rx.
interface uart_cmd_bridge_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_PKT_LEN = 16
);
    logic [CMD_PKT_LEN-1:0] cmd;
    logic                   uart_valid;
    logic                   uart_ready;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   read_valid;
    logic                   read_ready;
    logic                   err_parity;
    logic                   err_frame;
    logic                   err_overflow;
    logic                   err_clear;
    logic                   tx;
    logic                   rx;

    modport master (
        output cmd, uart_valid, read_ready, err_clear, rx,
        input  uart_ready, read_data, read_valid, err_parity, err_frame, err_overflow, tx
    );

    modport slave (
        input  cmd, uart_valid, read_ready, err_clear, rx,
        output uart_ready, read_data, read_valid, err_parity, err_frame, err_overflow, tx
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Command packets out as MS-word-first UART frames; received frames into a FIFO read port.
// Start bit one cycle after accept, uart_ready low for the packet; RX push 2 sync cycles + mid-stop sample.
module uart_cmd_bridge #(
    parameter int DATA_WIDTH    = 8,
    parameter int SYS_CLK_FREQ  = 50_000_000,
    parameter int BPS           = 9_600,
    parameter int CMD_PKT_LEN   = 16,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_bridge_if.slave   bus
);
    localparam int CPB    = SYS_CLK_FREQ / BPS;
    localparam int HALF   = CPB / 2;
    localparam int CW     = $clog2(CPB + 1);
    localparam int NWORDS = CMD_PKT_LEN / DATA_WIDTH;
    localparam int WW     = $clog2(NWORDS + 1);
    localparam int ADDR   = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    tx_state_t              tx_state_q;
    logic [CW-1:0]          tx_cnt_q;
    logic [3:0]             tx_bit_q;
    logic [WW-1:0]          tx_word_q;
    logic [CMD_PKT_LEN-1:0] tx_pkt_q;
    logic [DATA_WIDTH-1:0]  tx_shift_q;
    logic                   tx_q;
    logic                   uart_ready_q;
    logic [DATA_WIDTH-1:0]  tx_word;
    logic                   tx_par;

    assign tx_word = tx_pkt_q[CMD_PKT_LEN-1 -: DATA_WIDTH];
    assign tx_par  = (PARITY_MODE == 2) ? ~^tx_word : ^tx_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_word_q    <= '0;
            tx_pkt_q     <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            uart_ready_q <= 1'b1;
        end else if (tx_state_q == TX_IDLE) begin
            if (bus.uart_valid && uart_ready_q) begin
                tx_pkt_q     <= bus.cmd;
                uart_ready_q <= 1'b0;
                tx_state_q   <= TX_START;
                tx_q         <= 1'b0;
                tx_cnt_q     <= '0;
                tx_word_q    <= '0;
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end else begin
            tx_cnt_q <= '0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_q <= TX_DATA;
                    tx_bit_q   <= '0;
                    tx_shift_q <= tx_word;
                    tx_q       <= tx_word[0];
                end
                TX_DATA: begin
                    if (tx_bit_q == 4'(DATA_WIDTH - 1)) begin
                        tx_bit_q   <= '0;
                        tx_state_q <= (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
                        tx_q       <= (PARITY_MODE != 0) ? tx_par : 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 4'd1;
                        tx_q       <= tx_shift_q[1];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
                TX_PARITY: begin
                    tx_state_q <= TX_STOP;
                    tx_q       <= 1'b1;
                end
                TX_STOP: begin
                    if (tx_bit_q != 4'(STOP_BITS - 1)) begin
                        tx_bit_q <= tx_bit_q + 4'd1;
                    end else if (tx_word_q == WW'(NWORDS - 1)) begin
                        tx_state_q   <= TX_IDLE;
                        uart_ready_q <= 1'b1;
                    end else begin
                        // next word follows the last stop bit with no gap
                        tx_word_q  <= tx_word_q + WW'(1);
                        tx_pkt_q   <= tx_pkt_q << DATA_WIDTH;
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_s1_d, rx_s2_d, rx_prev_d;

    always_comb begin
        rx_s1_d   = bus.rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    rx_state_t             rx_state_q;
    logic [CW-1:0]         rx_cnt_q;
    logic [3:0]            rx_bit_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_par_q;
    logic                  rx_fall;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // a line already high again at mid start bit was a glitch
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q  <= '0;
                        rx_data_q <= {rx_s2_q, rx_data_q[DATA_WIDTH-1:1]};
                        if (rx_bit_q == 4'(DATA_WIDTH - 1)) begin
                            rx_state_q <= (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 4'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    logic stop_sample, rx_good, rx_par_exp, rx_par_bad, rx_frame_bad;

    assign stop_sample  = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
    assign rx_good      = stop_sample & rx_s2_q;
    assign rx_frame_bad = stop_sample & ~rx_s2_q;
    assign rx_par_exp   = (PARITY_MODE == 2) ? ~^rx_data_q : ^rx_data_q;
    assign rx_par_bad   = rx_good && (PARITY_MODE != 0) && (rx_par_q != rx_par_exp);

    logic [DATA_WIDTH-1:0] mem_q [RX_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RX_FIFO_DEPTH];
    logic [ADDR:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  fifo_empty, fifo_full, pop, push, overflow;
    logic                  err_parity_q, err_parity_d;
    logic                  err_frame_q, err_frame_d;
    logic                  err_overflow_q, err_overflow_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                        (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
    assign pop        = !fifo_empty && bus.read_ready;
    assign push       = rx_good && (!fifo_full || pop);
    assign overflow   = rx_good && fifo_full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR-1:0]] = rx_data_q;
            wr_ptr_d = wr_ptr_q + (ADDR+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (ADDR+1)'(1);
        end
        // a new event outranks a coincident clear
        err_parity_d   = rx_par_bad   | (err_parity_q   & ~bus.err_clear);
        err_frame_d    = rx_frame_bad | (err_frame_q    & ~bus.err_clear);
        err_overflow_d = overflow     | (err_overflow_q & ~bus.err_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            err_parity_q   <= 1'b0;
            err_frame_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            err_parity_q   <= err_parity_d;
            err_frame_q    <= err_frame_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.uart_ready   = uart_ready_q;
    assign bus.tx           = tx_q;
    assign bus.read_valid   = !fifo_empty;
    assign bus.read_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR-1:0]];
    assign bus.err_parity   = err_parity_q;
    assign bus.err_frame    = err_frame_q;
    assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Three bridge configurations: A (8b, odd parity, loopback), B (8b, even parity, 2 stops, driven rx),
// C (6b words, 3 per packet, no parity, loopback); reference bit streams built from the frame format.
module tb_uart_cmd_bridge;
    localparam int SYS  = 1_600_000;
    localparam int BAUD = 100_000;
    localparam int CPB  = SYS / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_bridge_if #(.DATA_WIDTH(8), .CMD_PKT_LEN(16)) ifa ();
    uart_cmd_bridge_if #(.DATA_WIDTH(8), .CMD_PKT_LEN(16)) ifb ();
    uart_cmd_bridge_if #(.DATA_WIDTH(6), .CMD_PKT_LEN(18)) ifc ();

    assign ifa.rx = ifa.tx;
    assign ifc.rx = ifc.tx;

    uart_cmd_bridge #(.DATA_WIDTH(8), .SYS_CLK_FREQ(SYS), .BPS(BAUD), .CMD_PKT_LEN(16),
                      .PARITY_MODE(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    uart_cmd_bridge #(.DATA_WIDTH(8), .SYS_CLK_FREQ(SYS), .BPS(BAUD), .CMD_PKT_LEN(16),
                      .PARITY_MODE(1), .STOP_BITS(2), .RX_FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    uart_cmd_bridge #(.DATA_WIDTH(6), .SYS_CLK_FREQ(SYS), .BPS(BAUD), .CMD_PKT_LEN(18),
                      .PARITY_MODE(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    logic m_par = 1'b0, m_frame = 1'b0, m_ovf = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cfg_dw(int d); return (d == 2) ? 6 : 8; endfunction
    function automatic int cfg_nw(int d); return (d == 2) ? 3 : 2; endfunction
    function automatic int cfg_pm(int d); return (d == 0) ? 2 : (d == 1) ? 1 : 0; endfunction
    function automatic int cfg_ns(int d); return (d == 1) ? 2 : 1; endfunction

    function automatic logic get_tx(int d);
        case (d) 0: return ifa.tx; 1: return ifb.tx; default: return ifc.tx; endcase
    endfunction
    function automatic logic get_ready(int d);
        case (d) 0: return ifa.uart_ready; 1: return ifb.uart_ready; default: return ifc.uart_ready; endcase
    endfunction
    function automatic logic get_rvalid(int d);
        case (d) 0: return ifa.read_valid; 1: return ifb.read_valid; default: return ifc.read_valid; endcase
    endfunction
    function automatic logic [31:0] get_rdata(int d);
        case (d)
            0: return 32'(ifa.read_data);
            1: return 32'(ifb.read_data);
            default: return 32'(ifc.read_data);
        endcase
    endfunction
    function automatic logic [31:0] get_errs(int d);
        case (d)
            0: return 32'({ifa.err_parity, ifa.err_frame, ifa.err_overflow});
            1: return 32'({ifb.err_parity, ifb.err_frame, ifb.err_overflow});
            default: return 32'({ifc.err_parity, ifc.err_frame, ifc.err_overflow});
        endcase
    endfunction

    task automatic set_cmd(int d, logic [31:0] pkt, logic v);
        case (d)
            0: begin ifa.cmd = 16'(pkt); ifa.uart_valid = v; end
            1: begin ifb.cmd = 16'(pkt); ifb.uart_valid = v; end
            default: begin ifc.cmd = 18'(pkt); ifc.uart_valid = v; end
        endcase
    endtask
    task automatic set_rready(int d, logic v);
        case (d) 0: ifa.read_ready = v; 1: ifb.read_ready = v; default: ifc.read_ready = v; endcase
    endtask

    function automatic logic [31:0] word_of(int d, logic [31:0] pkt, int w);
        logic [31:0] mask;
        mask = (32'd1 << cfg_dw(d)) - 32'd1;
        return (pkt >> ((cfg_nw(d) - 1 - w) * cfg_dw(d))) & mask;
    endfunction

    // Called at a negedge; returns at the negedge where uart_ready should be back.
    task automatic send_pkt(int d, logic [31:0] pkt, string tag);
        logic exp_bits[$];
        logic [31:0] word;
        logic odd_ones;
        int total;
        for (int w = 0; w < cfg_nw(d); w++) begin
            word = word_of(d, pkt, w);
            odd_ones = ($countones(word) % 2) == 1;
            exp_bits.push_back(1'b0);
            for (int i = 0; i < cfg_dw(d); i++) exp_bits.push_back(word[i]);
            if (cfg_pm(d) == 1) exp_bits.push_back(odd_ones);
            if (cfg_pm(d) == 2) exp_bits.push_back(!odd_ones);
            for (int s = 0; s < cfg_ns(d); s++) exp_bits.push_back(1'b1);
        end
        total = exp_bits.size();
        chk({tag, "_ready_idle"}, 32'(get_ready(d)), 32'd1);
        set_cmd(d, pkt, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_cmd(d, pkt, 1'b0);
        chk({tag, "_ready_drop"}, 32'(get_ready(d)), 32'd0);
        for (int c = 0; c < total * CPB; c++) begin
            if (c % CPB == CPB / 2) chk({tag, "_bit"}, 32'(get_tx(d)), 32'(exp_bits[c / CPB]));
            if (c == total * CPB - 1) chk({tag, "_ready_last"}, 32'(get_ready(d)), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_ready_back"}, 32'(get_ready(d)), 32'd1);
        chk({tag, "_tx_idle"}, 32'(get_tx(d)), 32'd1);
    endtask

    task automatic drain_loop(int d, logic [31:0] pkt, string tag);
        for (int w = 0; w < cfg_nw(d); w++) begin
            chk({tag, "_rvalid"}, 32'(get_rvalid(d)), 32'd1);
            chk({tag, "_rdata"}, get_rdata(d), word_of(d, pkt, w));
            set_rready(d, 1'b1);
            @(negedge clk);
            set_rready(d, 1'b0);
        end
        chk({tag, "_empty"}, 32'(get_rvalid(d)), 32'd0);
        chk({tag, "_errs"}, get_errs(1'b0 ? 0 : d), 32'd0);
    endtask

    // Even-parity, two-stop frame on B's rx, followed by two idle bit-times.
    task automatic drive_frame(logic [7:0] data, bit par_ok, bit stop_ok);
        logic seq[$];
        logic par;
        par = ($countones(data) % 2) == 1;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(data[i]);
        seq.push_back(par_ok ? par : !par);
        seq.push_back(logic'(stop_ok));
        seq.push_back(1'b1);
        seq.push_back(1'b1);
        seq.push_back(1'b1);
        foreach (seq[i]) begin
            ifb.rx = seq[i];
            repeat (CPB) @(negedge clk);
        end
        if (!stop_ok) m_frame = 1'b1;
        else if (mq.size() == 4) m_ovf = 1'b1;
        else begin
            mq.push_back(data);
            if (!par_ok) m_par = 1'b1;
        end
    endtask

    task automatic b_check(string tag);
        chk({tag, "_rvalid"}, 32'(get_rvalid(1)), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, "_rdata"}, get_rdata(1), 32'(mq[0]));
        chk({tag, "_errs"}, get_errs(1), 32'({m_par, m_frame, m_ovf}));
    endtask

    task automatic b_pop(string tag);
        b_check(tag);
        ifb.read_ready = 1'b1;
        @(negedge clk);
        ifb.read_ready = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic b_clear();
        ifb.err_clear = 1'b1;
        @(negedge clk);
        ifb.err_clear = 1'b0;
        m_par = 1'b0; m_frame = 1'b0; m_ovf = 1'b0;
        b_check("b_clear");
    endtask

    initial begin
        logic [31:0] p;
        for (int d = 0; d < 3; d++) begin
            set_cmd(d, 32'd0, 1'b0);
            set_rready(d, 1'b0);
        end
        ifa.err_clear = 1'b0; ifb.err_clear = 1'b0; ifc.err_clear = 1'b0;
        ifb.rx = 1'b1;
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("rst_tx", 32'(get_tx(d)), 32'd1);
            chk("rst_ready", 32'(get_ready(d)), 32'd1);
            chk("rst_rvalid", 32'(get_rvalid(d)), 32'd0);
            chk("rst_rdata", get_rdata(d), 32'd0);
            chk("rst_errs", get_errs(d), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of A's start bit
        set_cmd(0, 32'h5A3C, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_cmd(0, 32'h5A3C, 1'b0);
        repeat (CPB / 2) @(negedge clk);
        chk("midrst_pre_tx", 32'(get_tx(0)), 32'd0);
        chk("midrst_pre_ready", 32'(get_ready(0)), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(get_tx(0)), 32'd1);
        chk("midrst_ready", 32'(get_ready(0)), 32'd1);
        chk("midrst_rvalid", 32'(get_rvalid(0)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_pkt(0, 32'h1234, "a_fixed");
        drain_loop(0, 32'h1234, "a_fixed_rx");
        for (int k = 0; k < 4; k++) begin
            p = $urandom & 32'hFFFF;
            send_pkt(0, p, "a_rand");
            drain_loop(0, p, "a_rand_rx");
        end

        send_pkt(1, 32'h0103, "b_fixed");
        for (int k = 0; k < 3; k++) send_pkt(1, $urandom & 32'hFFFF, "b_rand");

        send_pkt(2, 32'h2A5C3, "c_fixed");
        drain_loop(2, 32'h2A5C3, "c_fixed_rx");
        for (int k = 0; k < 4; k++) begin
            p = $urandom & 32'h3FFFF;
            send_pkt(2, p, "c_rand");
            drain_loop(2, p, "c_rand_rx");
        end

        for (int k = 0; k < 3; k++) begin
            drive_frame(8'($urandom), 1'b1, 1'b1);
            b_check("b_rx_good");
        end
        while (mq.size() != 0) b_pop("b_pop_good");
        drive_frame(8'hC5, 1'b0, 1'b1);
        b_check("b_rx_badpar");
        drive_frame(8'h3E, 1'b1, 1'b0);
        b_check("b_rx_badstop");
        while (mq.size() != 0) b_pop("b_pop_err");
        b_clear();

        for (int k = 0; k < 5; k++) drive_frame(8'($urandom), 1'b1, 1'b1);
        b_check("b_rx_ovf");
        while (mq.size() != 0) b_pop("b_pop_ovf");
        b_check("b_ovf_empty");
        b_clear();

        ifb.rx = 1'b0;
        repeat (3) @(negedge clk);
        ifb.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        b_check("b_glitch");
        drive_frame(8'h96, 1'b1, 1'b1);
        b_check("b_after_glitch");
        b_pop("b_pop_glitch");
        b_check("b_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
